// File: rtl/ctrl_pkg.sv
// Shared decode constants, ALU encodings and the ID/EX control bundle.
// The bne field only exists when CTRL_EXT_OPS_EN is defined.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

`ifdef CTRL_EXT_OPS_EN
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
`endif

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_NOP  = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;

    typedef struct packed {
        logic        reg_write;
        logic        reg_dst;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        alu_src;
        logic        mem_to_reg;
`ifdef CTRL_EXT_OPS_EN
        logic        bne;
`endif
        logic        illegal;
        logic [3:0]  alu;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wr;
        logic [15:0] imm;
    } ctrl_bundle_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_e;

    function automatic ctrl_bundle_t idle_bundle();
        ctrl_bundle_t b;
        b     = '0;
        b.alu = ALU_NOP;
        return b;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational MIPS control decode: instruction word to control bundle plus operand-usage flags.
// No latency, no flow control; CTRL_EXT_OPS_EN adds ORI, SLTI, BNE and NOR.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [31:0]  instr_i,
    output ctrl_bundle_t bundle_o,
    output logic         rs_used_o,
    output logic         rt_used_o
);

    logic [5:0]   opcode;
    logic [5:0]   funct;
    logic [4:0]   rs;
    logic [4:0]   rt;
    logic [4:0]   rd;
    logic [15:0]  imm;
    logic         legal;
    ctrl_bundle_t b;

    assign opcode = instr_i[31:26];
    assign rs     = instr_i[25:21];
    assign rt     = instr_i[20:16];
    assign rd     = instr_i[15:11];
    assign funct  = instr_i[5:0];
    assign imm    = instr_i[15:0];

    always_comb begin
        b         = idle_bundle();
        b.rs      = rs;
        b.rt      = rt;
        b.imm     = imm;
        legal     = 1'b1;
        rs_used_o = 1'b0;
        rt_used_o = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                b.reg_write = 1'b1;
                b.reg_dst   = 1'b1;
                b.wr        = rd;
                rs_used_o   = 1'b1;
                rt_used_o   = 1'b1;
                case (funct)
                    FN_ADD:  b.alu = ALU_ADD;
                    FN_SUB:  b.alu = ALU_SUB;
                    FN_AND:  b.alu = ALU_AND;
                    FN_OR:   b.alu = ALU_OR;
                    FN_SLT:  b.alu = ALU_SLT;
`ifdef CTRL_EXT_OPS_EN
                    FN_NOR:  b.alu = ALU_NOR;
`endif
                    default: legal = 1'b0;
                endcase
            end
            OP_ADDI: begin
                b.reg_write = 1'b1;
                b.alu_src   = 1'b1;
                b.alu       = ALU_ADD;
                b.wr        = rt;
                rs_used_o   = 1'b1;
            end
            OP_ANDI: begin
                b.reg_write = 1'b1;
                b.alu_src   = 1'b1;
                b.alu       = ALU_AND;
                b.wr        = rt;
                rs_used_o   = 1'b1;
            end
            OP_LW: begin
                b.reg_write  = 1'b1;
                b.alu_src    = 1'b1;
                b.mem_read   = 1'b1;
                b.mem_to_reg = 1'b1;
                b.alu        = ALU_ADD;
                b.wr         = rt;
                rs_used_o    = 1'b1;
            end
            OP_SW: begin
                b.alu_src   = 1'b1;
                b.mem_write = 1'b1;
                b.alu       = ALU_ADD;
                rs_used_o   = 1'b1;
                rt_used_o   = 1'b1;
            end
            OP_BEQ: begin
                b.branch  = 1'b1;
                b.alu     = ALU_SUB;
                rs_used_o = 1'b1;
                rt_used_o = 1'b1;
            end
            OP_J: begin
                b.jump = 1'b1;
            end
`ifdef CTRL_EXT_OPS_EN
            OP_ORI: begin
                b.reg_write = 1'b1;
                b.alu_src   = 1'b1;
                b.alu       = ALU_OR;
                b.wr        = rt;
                rs_used_o   = 1'b1;
            end
            OP_SLTI: begin
                b.reg_write = 1'b1;
                b.alu_src   = 1'b1;
                b.alu       = ALU_SLT;
                b.wr        = rt;
                rs_used_o   = 1'b1;
            end
            OP_BNE: begin
                b.branch  = 1'b1;
                b.bne     = 1'b1;
                b.alu     = ALU_SUB;
                rs_used_o = 1'b1;
                rt_used_o = 1'b1;
            end
`endif
            default: legal = 1'b0;
        endcase
        // Unknown encodings still travel as a valid bundle, but with every control cleared.
        if (!legal) begin
            b         = idle_bundle();
            b.rs      = rs;
            b.rt      = rt;
            b.imm     = imm;
            b.illegal = 1'b1;
            rs_used_o = 1'b0;
            rt_used_o = 1'b0;
        end
    end

    assign bundle_o = b;

endmodule

// File: rtl/pipe_decode_ctrl.sv
// ID/EX control register with load-use bubble insertion and flush; CTRL_EXT_OPS_EN adds ORI/SLTI/BNE/NOR and the bne port.
// Latency 1 cycle; bundle holds while out_ready is low, in_ready drops on back-pressure, hazard, STALL or flush.
module pipe_decode_ctrl
    import ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W     = 4,
    parameter int REG_ADDR_W     = 5,
    parameter int LOAD_USE_STALL = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           instr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  reg_write,
    output logic                  reg_dst,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  branch,
    output logic                  jump,
    output logic                  alu_src,
    output logic                  mem_to_reg,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic [REG_ADDR_W-1:0] rs_addr,
    output logic [REG_ADDR_W-1:0] rt_addr,
    output logic [REG_ADDR_W-1:0] wr_addr,
    output logic [15:0]           imm,
    output logic                  illegal,
`ifdef CTRL_EXT_OPS_EN
    output logic                  bne,
`endif
    output logic                  stall
);

    ctrl_bundle_t dec_bundle;
    logic         rs_used;
    logic         rt_used;

    ctrl_decode u_dec (
        .instr_i   (instr),
        .bundle_o  (dec_bundle),
        .rs_used_o (rs_used),
        .rt_used_o (rt_used)
    );

    state_e       state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         out_valid_q, out_valid_d;
    ctrl_bundle_t bundle_q, bundle_d;
    logic         advance;
    logic         hazard;
    logic         accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            bundle_q    <= idle_bundle();
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            bundle_q    <= bundle_d;
        end
    end

    // A load writing r0 never produces a value worth waiting for.
    assign hazard = out_valid_q & bundle_q.mem_read & (bundle_q.wr != 5'd0) & in_valid &
                    ((rs_used & (bundle_q.wr == dec_bundle.rs)) |
                     (rt_used & (bundle_q.wr == dec_bundle.rt)));

    assign advance  = out_ready | ~out_valid_q;
    assign in_ready = advance & (state_q == ST_RUN) & ~hazard & ~flush;
    assign accept   = in_valid & in_ready;
    assign stall    = hazard | (state_q == ST_STALL);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        bundle_d    = bundle_q;
        if (flush) begin
            state_d     = ST_RUN;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            bundle_d    = idle_bundle();
        end else if (advance) begin
            if (accept) begin
                out_valid_d = 1'b1;
                bundle_d    = dec_bundle;
            end else begin
                out_valid_d = 1'b0;
                bundle_d    = idle_bundle();
            end
            case (state_q)
                ST_RUN: begin
                    // The hazard cycle itself is the first bubble; STALL covers the rest.
                    if (hazard && (LOAD_USE_STALL > 1)) begin
                        state_d = ST_STALL;
                        cnt_d   = 2'(LOAD_USE_STALL - 1);
                    end
                end
                ST_STALL: begin
                    if (cnt_q == 2'd1) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign out_valid   = out_valid_q;
    assign reg_write   = bundle_q.reg_write;
    assign reg_dst     = bundle_q.reg_dst;
    assign mem_read    = bundle_q.mem_read;
    assign mem_write   = bundle_q.mem_write;
    assign branch      = bundle_q.branch;
    assign jump        = bundle_q.jump;
    assign alu_src     = bundle_q.alu_src;
    assign mem_to_reg  = bundle_q.mem_to_reg;
    assign alu_control = ALU_CTRL_W'(bundle_q.alu);
    assign rs_addr     = REG_ADDR_W'(bundle_q.rs);
    assign rt_addr     = REG_ADDR_W'(bundle_q.rt);
    assign wr_addr     = REG_ADDR_W'(bundle_q.wr);
    assign imm         = bundle_q.imm;
    assign illegal     = bundle_q.illegal;
`ifdef CTRL_EXT_OPS_EN
    assign bne         = bundle_q.bne;
`endif

endmodule

// File: tb/tb_pipe_decode_ctrl.sv
// Bench for pipe_decode_ctrl: one instance with single-bubble load-use, one with three-bubble load-use.
module tb_pipe_decode_ctrl;

    typedef struct packed {
        logic       rw, rd, mr, mw, br, jp, asrc, m2r;
        logic [3:0] alu;
        logic [4:0] wr;
        logic       ill;
    } obs_t;

    typedef struct {
        logic [31:0] ins;
        obs_t        e;
        bit          nowait;
    } vec_t;

    localparam int NV = 17;
    localparam bit [4:0] L3_OV = 5'b10001;
    localparam bit [3:0] L3_IR = 4'b1000;
    localparam bit [3:0] L3_ST = 4'b0111;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        flush1, in_valid1, out_ready1, in_ready1, out_valid1;
    logic [31:0] instr1;
    logic        rw1, rd1, mr1, mw1, br1, jp1, as1, m2r1, ill1, stall1;
    logic [3:0]  alu1;
    logic [4:0]  rs1, rt1, wr1;
    logic [15:0] imm1;

    logic        flush3, in_valid3, out_ready3, in_ready3, out_valid3;
    logic [31:0] instr3;
    logic        rw3, rd3, mr3, mw3, br3, jp3, as3, m2r3, ill3, stall3;
    logic [3:0]  alu3;
    logic [4:0]  rs3, rt3, wr3;
    logic [15:0] imm3;
`ifdef CTRL_EXT_OPS_EN
    logic        bne1, bne3;
`endif

    pipe_decode_ctrl #(.ALU_CTRL_W(4), .REG_ADDR_W(5), .LOAD_USE_STALL(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush1), .in_valid(in_valid1), .in_ready(in_ready1),
        .instr(instr1), .out_valid(out_valid1), .out_ready(out_ready1), .reg_write(rw1),
        .reg_dst(rd1), .mem_read(mr1), .mem_write(mw1), .branch(br1), .jump(jp1),
        .alu_src(as1), .mem_to_reg(m2r1), .alu_control(alu1), .rs_addr(rs1), .rt_addr(rt1),
        .wr_addr(wr1), .imm(imm1), .illegal(ill1),
`ifdef CTRL_EXT_OPS_EN
        .bne(bne1),
`endif
        .stall(stall1)
    );

    pipe_decode_ctrl #(.ALU_CTRL_W(4), .REG_ADDR_W(5), .LOAD_USE_STALL(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .flush(flush3), .in_valid(in_valid3), .in_ready(in_ready3),
        .instr(instr3), .out_valid(out_valid3), .out_ready(out_ready3), .reg_write(rw3),
        .reg_dst(rd3), .mem_read(mr3), .mem_write(mw3), .branch(br3), .jump(jp3),
        .alu_src(as3), .mem_to_reg(m2r3), .alu_control(alu3), .rs_addr(rs3), .rt_addr(rt3),
        .wr_addr(wr3), .imm(imm3), .illegal(ill3),
`ifdef CTRL_EXT_OPS_EN
        .bne(bne3),
`endif
        .stall(stall3)
    );

    obs_t obs1, obs3;
    assign obs1 = {rw1, rd1, mr1, mw1, br1, jp1, as1, m2r1, alu1, wr1, ill1};
    assign obs3 = {rw3, rd3, mr3, mw3, br3, jp3, as3, m2r3, alu3, wr3, ill3};

    int   total = 0;
    int   bad   = 0;
    obs_t sbq[$];
    obs_t cur_exp1;
    bit   sb_en = 1'b0;
    vec_t tbl[NV];

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic chkn(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic chko(input string nm, input obs_t act, input obs_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic obs_t mk(input bit rw, rd, mr, mw, br, jp, asrc, m2r,
                                input logic [3:0] alu, input logic [4:0] wr, input bit ill);
        return {rw, rd, mr, mw, br, jp, asrc, m2r, alu, wr, ill};
    endfunction

    // Scoreboard: expectation queued on input handshake, compared on output handshake.
    always @(negedge clk) begin : sb_mon
        obs_t e;
        if (sb_en && rst_n) begin
            if (out_valid1 && out_ready1) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_extra: got bundle %h want none", obs1);
                end else begin
                    e = sbq.pop_front();
                    chko("sb_bundle", obs1, e);
                end
            end
            if (in_valid1 && in_ready1) sbq.push_back(cur_exp1);
        end
    end

    task automatic drive1(input logic [31:0] ins, input obs_t e);
        instr1    = ins;
        cur_exp1  = e;
        in_valid1 = 1'b1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the instruction is accepted.
    task automatic send1(input logic [31:0] ins, input obs_t e, output int waits);
        waits = 0;
        drive1(ins, e);
        @(negedge clk);
        while (!in_ready1 && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        if (!in_ready1) chk1("send_timeout", in_ready1, 1'b1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   n;
        obs_t o_rst, o_add, o_lw, o_addi, o_andi, o_ill;
        o_rst  = mk(0,0,0,0,0,0,0,0, 4'b0100, 5'd0, 0);
        o_ill  = mk(0,0,0,0,0,0,0,0, 4'b0100, 5'd0, 1);
        o_add  = mk(1,1,0,0,0,0,0,0, 4'b0010, 5'd3, 0);
        o_lw   = mk(1,0,1,0,0,0,1,1, 4'b0010, 5'd5, 0);
        o_addi = mk(1,0,0,0,0,0,1,0, 4'b0010, 5'd4, 0);
        o_andi = mk(1,0,0,0,0,0,1,0, 4'b0000, 5'd4, 0);

        tbl[0]  = '{32'h00221820, o_add, 1'b0};
        tbl[1]  = '{32'h8C250004, o_lw, 1'b0};
        tbl[2]  = '{32'h00E83022, mk(1,1,0,0,0,0,0,0, 4'b0110, 5'd6, 0), 1'b1};
        tbl[3]  = '{32'h00224824, mk(1,1,0,0,0,0,0,0, 4'b0000, 5'd9, 0), 1'b0};
        tbl[4]  = '{32'h00225025, mk(1,1,0,0,0,0,0,0, 4'b0001, 5'd10, 0), 1'b0};
        tbl[5]  = '{32'h0022582A, mk(1,1,0,0,0,0,0,0, 4'b0111, 5'd11, 0), 1'b0};
        tbl[6]  = '{32'h20240007, o_addi, 1'b0};
        tbl[7]  = '{32'h302400FF, o_andi, 1'b0};
        tbl[8]  = '{32'hACC20000, mk(0,0,0,1,0,0,1,0, 4'b0010, 5'd0, 0), 1'b0};
        tbl[9]  = '{32'h10220003, mk(0,0,0,0,1,0,0,0, 4'b0110, 5'd0, 0), 1'b0};
        tbl[10] = '{32'h08000010, mk(0,0,0,0,0,1,0,0, 4'b0100, 5'd0, 0), 1'b0};
        tbl[11] = '{32'hFC000000, o_ill, 1'b0};
        tbl[12] = '{32'h00221801, o_ill, 1'b0};
`ifdef CTRL_EXT_OPS_EN
        tbl[13] = '{32'h34240001, mk(1,0,0,0,0,0,1,0, 4'b0001, 5'd4, 0), 1'b0};
`else
        tbl[13] = '{32'h34240001, o_ill, 1'b0};
`endif
        tbl[14] = '{32'h8C200000, mk(1,0,1,0,0,0,1,1, 4'b0010, 5'd0, 0), 1'b0};
        tbl[15] = '{32'h00041820, o_add, 1'b1};
        tbl[16] = '{32'h00220020, mk(1,1,0,0,0,0,0,0, 4'b0010, 5'd0, 0), 1'b0};

        rst_n = 1'b0;
        flush1 = 1'b0; in_valid1 = 1'b0; instr1 = '0; out_ready1 = 1'b1; cur_exp1 = o_rst;
        flush3 = 1'b0; in_valid3 = 1'b0; instr3 = '0; out_ready3 = 1'b1;
        repeat (2) @(negedge clk);
        chk1("rst_ov1", out_valid1, 1'b0);
        chko("rst_bundle1", obs1, o_rst);
        chkn("rst_addr_imm1", int'({rs1, rt1, imm1}), 0);
        chk1("rst_stall1", stall1, 1'b0);
        chk1("rst_ov3", out_valid3, 1'b0);
        chko("rst_bundle3", obs3, o_rst);
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb_en = 1'b1;

        // add then lw back to back, one output cycle each
        @(posedge clk); #1;
        drive1(32'h00221820, o_add);
        @(posedge clk); #1;
        drive1(32'h8C250004, o_lw);
        @(negedge clk);
        chk1("basic_add_ov", out_valid1, 1'b1);
        chko("basic_add", obs1, o_add);
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        @(negedge clk);
        chk1("basic_lw_ov", out_valid1, 1'b1);
        chko("basic_lw", obs1, o_lw);
        chkn("basic_lw_imm", int'(imm1), 4);
        chkn("basic_lw_rs", int'(rs1), 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk1("basic_idle", out_valid1, 1'b0);

        // single-bubble load-use: lw $2 then add reading $2
        @(posedge clk); #1;
        drive1(32'h8C220000, mk(1,0,1,0,0,0,1,1, 4'b0010, 5'd2, 0));
        @(posedge clk); #1;
        drive1(32'h00441820, o_add);
        @(negedge clk);
        chk1("lu1_ready_low", in_ready1, 1'b0);
        chk1("lu1_stall", stall1, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        chk1("lu1_bubble", out_valid1, 1'b0);
        chk1("lu1_ready_back", in_ready1, 1'b1);
        chk1("lu1_stall_clear", stall1, 1'b0);
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        @(negedge clk);
        chk1("lu1_add_ov", out_valid1, 1'b1);
        chko("lu1_add", obs1, o_add);

        // decode table through the scoreboard
        @(posedge clk); #1;
        for (int i = 0; i < NV; i++) begin
            send1(tbl[i].ins, tbl[i].e, n);
            if (tbl[i].nowait) chkn("tbl_no_stall", n, 0);
        end
        in_valid1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // back-pressure: addi held for 4 cycles while andi waits
        drive1(32'h20240007, o_addi);
        @(posedge clk); #1;
        out_ready1 = 1'b0;
        drive1(32'h302400FF, o_andi);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk1("bp_ready_low", in_ready1, 1'b0);
            chk1("bp_ov_hold", out_valid1, 1'b1);
            chko("bp_bundle_hold", obs1, o_addi);
            @(posedge clk); #1;
        end
        out_ready1 = 1'b1;
        @(negedge clk);
        chk1("bp_ready_back", in_ready1, 1'b1);
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        @(negedge clk);
        chko("bp_andi", obs1, o_andi);
        repeat (2) @(posedge clk);
        #1;
        chkn("sb_drained", sbq.size(), 0);

        // three-bubble load-use: lw $2 then sw $2 with out_ready low mid-stall
        instr3 = 32'h8C220000; in_valid3 = 1'b1;
        @(posedge clk); #1;
        instr3 = 32'hACC20000;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk1("lu3_ov", out_valid3, L3_OV[c]);
            if (c < 4) begin
                chk1("lu3_ready", in_ready3, L3_IR[c]);
                chk1("lu3_stall", stall3, L3_ST[c]);
            end else begin
                chk1("lu3_sw", mw3, 1'b1);
            end
            @(posedge clk); #1;
            out_ready3 = (c == 0 || c == 1) ? 1'b0 : 1'b1;
            if (c == 3) in_valid3 = 1'b0;
        end
        @(negedge clk);
        chk1("lu3_no_dup", out_valid3, 1'b0);

        // flush during STALL, then an illegal opcode is accepted at once
        @(posedge clk); #1;
        instr3 = 32'h8C220000; in_valid3 = 1'b1;
        @(posedge clk); #1;
        instr3 = 32'hACC20000;
        @(negedge clk);
        chk1("fl_hazard", stall3, 1'b1);
        @(posedge clk); #1;
        flush3 = 1'b1;
        @(negedge clk);
        chk1("fl_ready_low", in_ready3, 1'b0);
        chk1("fl_in_stall", stall3, 1'b1);
        @(posedge clk); #1;
        flush3 = 1'b0;
        instr3 = 32'hFC000000;
        @(negedge clk);
        chk1("fl_ov", out_valid3, 1'b0);
        chk1("fl_run", stall3, 1'b0);
        chk1("fl_ready", in_ready3, 1'b1);
        @(posedge clk); #1;
        in_valid3 = 1'b0;
        @(negedge clk);
        chk1("ill_ov", out_valid3, 1'b1);
        chko("ill_bundle", obs3, o_ill);

        // flush together with a hazard: no STALL entry
        @(posedge clk); #1;
        instr3 = 32'h8C220000; in_valid3 = 1'b1;
        @(posedge clk); #1;
        instr3 = 32'hACC20000; flush3 = 1'b1;
        @(negedge clk);
        chk1("fh_hazard", stall3, 1'b1);
        chk1("fh_ready_low", in_ready3, 1'b0);
        @(posedge clk); #1;
        flush3 = 1'b0;
        @(negedge clk);
        chk1("fh_ov", out_valid3, 1'b0);
        chk1("fh_run", stall3, 1'b0);
        chk1("fh_ready", in_ready3, 1'b1);
        @(posedge clk); #1;
        in_valid3 = 1'b0;
        @(negedge clk);
        chk1("fh_sw", mw3, 1'b1);

        // asynchronous reset while a bundle is held
        @(posedge clk); #1;
        out_ready1 = 1'b0;
        drive1(32'h00221820, o_add);
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        sb_en = 1'b0;
        @(negedge clk);
        chk1("mr_pre_ov", out_valid1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("mr_ov", out_valid1, 1'b0);
        chko("mr_bundle", obs1, o_rst);
        chk1("mr_stall", stall1, 1'b0);
        sbq.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready1 = 1'b1;
        sb_en = 1'b1;
        drive1(32'h8C250004, o_lw);
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        @(negedge clk);
        chk1("mr_after_ov", out_valid1, 1'b1);
        chko("mr_after_lw", obs1, o_lw);
        repeat (2) @(posedge clk);
        #1;
        chkn("sb_final_empty", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
